// File: rtl/alu_result_buffer.sv
// -----------------------------------------------------------------------------
// alu_result_buffer
//
// This block sits after the ALU. It stores each {status, result} pair from the
// ALU in a small FIFO. A slower consumer can then read the pairs at its own
// rate. The block also counts accepted results flagged as errors, counts
// dropped writes, and keeps a sticky overflow flag. Both counters saturate.
//
// Parameters
//   M       data width of the ALU result
//   DEPTH   number of FIFO entries (power of two, >= 2)
//   CNT_W   width of the error and drop counters
//   ERR_BIT index of the status bit that marks an error result
//
// Ports
//   i_clk         clock, rising edge
//   i_reset       asynchronous reset, active high
//   i_valid       write request (new ALU result this cycle)
//   i_result      ALU result
//   i_status      ALU status
//   i_rd_en       consumer read request
//   i_clr         synchronous clear of the counters and the overflow flag
//   o_rd_valid    read data is fresh this cycle (one-cycle pulse)
//   o_rd_result   result of the last entry read
//   o_rd_status   status of the last entry read
//   o_empty       FIFO holds 0 entries
//   o_full        FIFO holds DEPTH entries
//   o_count       current occupancy
//   o_err_count   accepted writes with the error bit set (saturating)
//   o_drop_count  rejected writes (saturating)
//   o_overflow    sticky: at least one write was dropped
// -----------------------------------------------------------------------------
module alu_result_buffer #(
  parameter int M       = 4,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 8,
  parameter int ERR_BIT = 3
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_valid,
  input  logic [M-1:0]               i_result,
  input  logic [3:0]                 i_status,
  input  logic                       i_rd_en,
  input  logic                       i_clr,
  output logic                       o_rd_valid,
  output logic [M-1:0]               o_rd_result,
  output logic [3:0]                 o_rd_status,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [CNT_W-1:0]           o_err_count,
  output logic [CNT_W-1:0]           o_drop_count,
  output logic                       o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = M + 4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);

  // Storage and state registers
  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q,    wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q,    rd_ptr_d;
  logic [CW-1:0]    count_q,     count_d;
  logic             rd_valid_q,  rd_valid_d;
  logic [M-1:0]     rd_result_q, rd_result_d;
  logic [3:0]       rd_status_q, rd_status_d;
  logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q,  drop_cnt_d;
  logic             overflow_q,  overflow_d;

  logic             wr_acc;
  logic             rd_acc;
  logic             drop_ev;
  logic [EW-1:0]    rd_entry;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == FULL_CNT);

  // A read is accepted only when the FIFO is not empty before the edge.
  // There is no bypass from write to read.
  // A write to a full FIFO is accepted only when a read frees a slot in
  // the same cycle.
  assign rd_acc   = i_rd_en & ~o_empty;
  assign wr_acc   = i_valid & (~o_full | rd_acc);
  assign drop_ev  = i_valid & ~wr_acc;
  assign rd_entry = mem_q[rd_ptr_q];

  // NOTE: every signal assigned in this block gets a default value first.
  // This prevents latches from being inferred on paths that do not assign it.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_valid_d  = 1'b0;
    rd_result_d = rd_result_q;
    rd_status_d = rd_status_q;
    err_cnt_d   = err_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    overflow_d  = overflow_q;

    // DEPTH is a power of two, so the pointers wrap when they overflow.
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);

    if (rd_acc) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      rd_valid_d  = 1'b1;
      rd_result_d = rd_entry[M-1:0];
      rd_status_d = rd_entry[EW-1:M];
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A clear in the same cycle as an increment wins, and the increment is lost.
    if (i_clr) begin
      err_cnt_d  = '0;
      drop_cnt_d = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr_acc && i_status[ERR_BIT] && (err_cnt_q != CNT_MAX))
        err_cnt_d = err_cnt_q + CNT_W'(1);
      if (drop_ev) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != CNT_MAX) drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: all sequential state uses non-blocking assignments. Each register
  // then updates from values taken before the edge, whatever the statement order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      rd_result_q <= '0;
      rd_status_q <= '0;
      err_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      rd_result_q <= rd_result_d;
      rd_status_q <= rd_status_d;
      err_cnt_q   <= err_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  // NOTE: the storage array is not reset. After reset the pointers and the
  // count mark every entry as invalid, so a stale entry can never be read.
  always_ff @(posedge i_clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= {i_status, i_result};
  end

  assign o_rd_valid   = rd_valid_q;
  assign o_rd_result  = rd_result_q;
  assign o_rd_status  = rd_status_q;
  assign o_count      = count_q;
  assign o_err_count  = err_cnt_q;
  assign o_drop_count = drop_cnt_q;
  assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// -----------------------------------------------------------------------------
// tb_alu_result_buffer
//
// Scoreboard bench for alu_result_buffer. The DUT is built with CNT_W=2 so
// that counter saturation can be reached quickly.
//
// Each cycle the bench updates a small reference model: a queue of stored
// entries plus the counters. When the model accepts a write, the entry is
// pushed to the queue. When the model accepts a read, the front entry is
// popped, and it must match the DUT read data one cycle later.
// -----------------------------------------------------------------------------
module tb_alu_result_buffer;

  localparam int M       = 4;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 2;
  localparam int ERR_BIT = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic         i_clk;
  logic         i_reset;
  logic         i_valid;
  logic [M-1:0] i_result;
  logic [3:0]   i_status;
  logic         i_rd_en;
  logic         i_clr;
  logic         o_rd_valid;
  logic [M-1:0] o_rd_result;
  logic [3:0]   o_rd_status;
  logic         o_empty;
  logic         o_full;
  logic [2:0]   o_count;
  logic [CNT_W-1:0] o_err_count;
  logic [CNT_W-1:0] o_drop_count;
  logic         o_overflow;

  alu_result_buffer #(
    .M(M), .DEPTH(DEPTH), .CNT_W(CNT_W), .ERR_BIT(ERR_BIT)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_valid     (i_valid),
    .i_result    (i_result),
    .i_status    (i_status),
    .i_rd_en     (i_rd_en),
    .i_clr       (i_clr),
    .o_rd_valid  (o_rd_valid),
    .o_rd_result (o_rd_result),
    .o_rd_status (o_rd_status),
    .o_empty     (o_empty),
    .o_full      (o_full),
    .o_count     (o_count),
    .o_err_count (o_err_count),
    .o_drop_count(o_drop_count),
    .o_overflow  (o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model
  logic [7:0] sb_q [$];
  logic [7:0] last_rd;
  int         m_err, m_drop;
  logic       m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("count",    32'(o_count),      32'(sb_q.size()));
    check("empty",    32'(o_empty),      32'(sb_q.size() == 0));
    check("full",     32'(o_full),       32'(sb_q.size() == DEPTH));
    check("err_cnt",  32'(o_err_count),  32'(m_err));
    check("drop_cnt", 32'(o_drop_count), 32'(m_drop));
    check("overflow", 32'(o_overflow),   32'(m_ovf));
  endtask

  // Drive one cycle of stimulus, advance the model, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [3:0] res, input logic [3:0] st,
                      input logic re, input logic clr);
    logic rd, wr;
    i_valid  = v;
    i_result = res;
    i_status = st;
    i_rd_en  = re;
    i_clr    = clr;
    rd = re && (sb_q.size() != 0);
    wr = v && ((sb_q.size() < DEPTH) || rd);
    if (rd) last_rd = sb_q.pop_front();
    if (wr) sb_q.push_back({st, res});
    if (clr) begin
      m_err = 0; m_drop = 0; m_ovf = 1'b0;
    end else begin
      if (wr && st[ERR_BIT] && m_err != CNT_MAX) m_err++;
      if (v && !wr) begin
        m_ovf = 1'b1;
        if (m_drop != CNT_MAX) m_drop++;
      end
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0; i_rd_en = 1'b0; i_clr = 1'b0;
    check("rd_valid", 32'(o_rd_valid), 32'(rd));
    check("rd_data",  32'({o_rd_status, o_rd_result}), 32'(last_rd));
    check_all();
  endtask

  task automatic wr(input logic [3:0] res, input logic [3:0] st);
    step(1'b1, res, st, 1'b0, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
  endtask

  // Assert reset between clock edges and check that the outputs clear at once.
  task automatic pulse_reset();
    i_reset = 1'b1;
    #2;
    sb_q.delete();
    m_err = 0; m_drop = 0; m_ovf = 1'b0; last_rd = '0;
    check("rst_rd_valid", 32'(o_rd_valid), 32'd0);
    check("rst_rd_data",  32'({o_rd_status, o_rd_result}), 32'd0);
    check_all();
    #2;
    i_reset = 1'b0;
  endtask

  initial begin
    i_reset = 1'b0; i_valid = 1'b0; i_result = '0; i_status = '0;
    i_rd_en = 1'b0; i_clr = 1'b0;
    sb_q.delete(); m_err = 0; m_drop = 0; m_ovf = 1'b0; last_rd = '0;
    @(posedge i_clk); #1;
    pulse_reset();

    // Basic in-order write/read
    wr(4'b1111, 4'b0110);
    wr(4'b1001, 4'b0100);
    wr(4'b0110, 4'b0000);
    repeat (3) rd();
    rd();  // read while empty is ignored

    // Fill to full, drop the 5th write, then write and read together while full
    for (int i = 1; i <= 5; i++) wr(4'(i), 4'b0001);
    for (int i = 5; i <= 7; i++) step(1'b1, 4'(i + 3), 4'b0010, 1'b1, 1'b0);
    repeat (4) rd();

    // Empty FIFO with write and read in the same cycle: only the write is accepted
    step(1'b1, 4'hA, 4'b0011, 1'b1, 1'b0);
    rd();

    // Error counting
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    wr(4'h1, 4'b1001);
    wr(4'h2, 4'b1001);
    wr(4'h3, 4'b1001);
    wr(4'h4, 4'b0100);
    repeat (4) rd();
    step(1'b1, 4'hC, 4'b1000, 1'b0, 1'b1);  // clear wins over the increment
    rd();
    for (int i = 0; i < 5; i++) begin
      wr(4'(i), 4'b1000);
      rd();
    end
    // Drop counter saturation
    for (int i = 0; i < 8; i++) wr(4'(i), 4'b0000);

    // Reset in the middle of a stream
    pulse_reset();
    wr(4'h5, 4'b0101);
    wr(4'h6, 4'b0110);
    pulse_reset();
    step(1'b1, 4'h7, 4'b0111, 1'b1, 1'b0);
    rd();
    rd();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
